instr_fetch_unit: RTL and testbench

- Producer side of the IF/ID interface. Generates PC_IF / Instr_IF for the IF/ID pipeline register and obeys that register's stall and flush controls.
- Owns the fetch PC and issues in-order requests to instruction memory using a req/gnt + rvalid protocol with variable latency.
- Buffers returned instructions in a small response FIFO. On a branch/jump redirect, discards every stale in-flight response.

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order imem requests under a credit limit,
// buffers responses for the IF/ID register and drops stale responses after a redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] Instr_IF,
  output logic        valid_IF
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fpc_reg, fpc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0] fifo_count_reg, fifo_count_next;
  logic [PW-1:0] tag_wr_reg, tag_rd_reg;
  logic [PW-1:0] fifo_wr_reg, fifo_rd_reg;
  logic [31:0]   last_pc_reg;

  logic [31:0]   tag_pc_reg     [DEPTH];
  logic [31:0]   fifo_pc_reg    [DEPTH];
  logic [31:0]   fifo_instr_reg [DEPTH];

  logic          granted;
  logic          pop;
  logic          drop;
  logic          push;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_IF = (fifo_count_reg != '0);
  assign PC_IF    = valid_IF ? fifo_pc_reg[fifo_rd_reg] : last_pc_reg;
  assign Instr_IF = valid_IF ? fifo_instr_reg[fifo_rd_reg] : NOP_INSTR;
  assign pop      = valid_IF & ~stall;

  // The entry leaving the FIFO this cycle frees its credit immediately, which is
  // what sustains one fetch per cycle against a zero-wait memory with DEPTH = 2.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg} - (CW+1)'(pop);
  assign imem_req    = reset & ~redirect & (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fpc_reg;
  assign granted     = imem_req & imem_gnt;

  // A response arriving during the redirect cycle is stale and is simply not kept.
  assign drop = imem_rvalid & (drop_cnt_reg != '0);
  assign push = imem_rvalid & ~drop & ~redirect;

  always_comb begin
    fpc_next         = fpc_reg;
    outstanding_next = outstanding_reg + CW'(granted) - CW'(imem_rvalid);
    drop_cnt_next    = drop_cnt_reg;
    fifo_count_next  = fifo_count_reg + CW'(push) - CW'(pop);
    if (redirect) begin
      fpc_next        = {redirect_PC[31:2], 2'b00};
      // Everything still in flight belongs to the old path, including earlier drops.
      drop_cnt_next   = outstanding_reg - CW'(imem_rvalid);
      fifo_count_next = '0;
    end else begin
      if (granted) begin
        fpc_next = fpc_reg + 32'd4;
      end
      if (drop) begin
        drop_cnt_next = drop_cnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_reg         <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      fifo_count_reg  <= '0;
      tag_wr_reg      <= '0;
      tag_rd_reg      <= '0;
      fifo_wr_reg     <= '0;
      fifo_rd_reg     <= '0;
      last_pc_reg     <= RESET_PC;
    end else begin
      fpc_reg         <= fpc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      fifo_count_reg  <= fifo_count_next;
      last_pc_reg     <= PC_IF;
      if (granted) begin
        tag_wr_reg <= ptr_inc(tag_wr_reg);
      end
      if (imem_rvalid) begin
        tag_rd_reg <= ptr_inc(tag_rd_reg);
      end
      if (redirect) begin
        fifo_wr_reg <= '0;
        fifo_rd_reg <= '0;
      end else begin
        if (push) begin
          fifo_wr_reg <= ptr_inc(fifo_wr_reg);
        end
        if (pop) begin
          fifo_rd_reg <= ptr_inc(fifo_rd_reg);
        end
      end
    end
  end

  // Payload storage carries no reset; the pointers above define what is valid.
  always_ff @(posedge clk) begin
    if (granted) begin
      tag_pc_reg[tag_wr_reg] <= fpc_reg;
    end
    if (push) begin
      fifo_pc_reg[fifo_wr_reg]    <= tag_pc_reg[tag_rd_reg];
      fifo_instr_reg[fifo_wr_reg] <= imem_rdata;
    end
  end

  a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (fifo_count_reg == CW'(DEPTH))));

  a_credit_limit : assert property (@(posedge clk) disable iff (!reset)
    (({1'b0, outstanding_reg} + {1'b0, fifo_count_reg}) <= (CW+1)'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with configurable latency,
// a fetch-stream scoreboard, a directed cycle table and redirect/wrap/reset sequences.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          DEPTH     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_PC = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PC_IF;
  logic [31:0] Instr_IF;
  logic        valid_IF;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_PC(redirect_PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .PC_IF      (PC_IF),
    .Instr_IF   (Instr_IF),
    .valid_IF   (valid_IF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mem_req_t;

  typedef struct {
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  fetch_t      exp_q[$];
  mem_req_t    mem_q[$];
  logic [31:0] grant_log[$];
  vec_t        vec[15];

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rand_lat_max = 0;
  bit          gnt_en = 1'b1;
  bit          rand_gnt = 1'b0;
  bit          rst_v = 1'b0;
  logic [31:0] model_fpc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // One clock: drive inputs after the falling edge, sample 1ns later, update models.
  task automatic tick(input bit s, input bit r, input logic [31:0] rpc);
    fetch_t   f;
    mem_req_t m;
    @(negedge clk);
    cyc++;
    reset       = rst_v;
    stall       = s;
    redirect    = r;
    redirect_PC = rpc;
    imem_gnt    = rand_gnt ? ($urandom_range(0, 3) != 0) : gnt_en;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (!rst_v) begin
      exp_q.delete();
      mem_q.delete();
      model_fpc = RESET_PC;
    end else if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    #1;
    if (rst_v) begin
      if (valid_IF) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: got pc %h instr %h, expected no valid output (cycle %0d)",
                   PC_IF, Instr_IF, cyc);
        end else begin
          check("sb_pc", PC_IF, exp_q[0].pc);
          check("sb_instr", Instr_IF, exp_q[0].instr);
          if (!s && !r) begin
            $display("fetch cycle %0d pc=%h instr=%h", cyc, PC_IF, Instr_IF);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("nop_when_invalid", Instr_IF, NOP_INSTR);
      end
      if (r) begin
        exp_q.delete();
        model_fpc = {rpc[31:2], 2'b00};
      end
      if (imem_req && imem_gnt) begin
        check("grant_addr", imem_addr, model_fpc);
        f.pc    = model_fpc;
        f.instr = mem_word(model_fpc);
        exp_q.push_back(f);
        m.addr  = imem_addr;
        m.ready = cyc + ((rand_lat_max > 0) ? int'($urandom_range(1, rand_lat_max)) : lat);
        mem_q.push_back(m);
        grant_log.push_back(imem_addr);
        model_fpc = model_fpc + 32'd4;
      end
    end
  endtask

  task automatic wait_req(input logic [31:0] target, input string name);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (imem_req) begin
        check(name, imem_addr, target);
        return;
      end
    end
    checks++;
    $display("FAIL %s: got no imem_req within 30 cycles, expected address %h", name, target);
  endtask

  task automatic wait_valid(input logic [31:0] target, input string name);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (valid_IF) begin
        check(name, PC_IF, target);
        return;
      end
    end
    checks++;
    $display("FAIL %s: got no valid_IF within 30 cycles, expected pc %h", name, target);
  endtask

  initial begin
    vec[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vec[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vec[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vec[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
    vec[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    vec[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    vec[6]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
    vec[7]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
    vec[8]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
    vec[9]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
    vec[10] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
    vec[11] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    vec[12] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    vec[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
    vec[14] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h1C};

    // Reset state
    rst_v = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(valid_IF), 32'd0);
    check("rst_pc", PC_IF, RESET_PC);
    check("rst_instr", Instr_IF, NOP_INSTR);

    // Reset release, zero-wait streaming, then a 5-cycle stall at pc 0x10
    rst_v = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(vec[i].stall, 1'b0, 32'h0);
      check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(vec[i].exp_req));
      check($sformatf("tbl%0d_addr", i), imem_addr, vec[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), 32'(valid_IF), 32'(vec[i].exp_valid));
      check($sformatf("tbl%0d_pc", i), PC_IF, vec[i].exp_pc);
      check($sformatf("tbl%0d_instr", i), Instr_IF,
            vec[i].exp_valid ? mem_word(vec[i].exp_pc) : NOP_INSTR);
    end

    // Latency 3: two requests in flight (0x20, 0x24), then redirect to 0x103
    lat = 3;
    grant_log.delete();
    tick(1'b0, 1'b1, 32'h0000_0020);
    for (int i = 0; i < 10 && grant_log.size() < 2; i++) tick(1'b0, 1'b0, 32'h0);
    check("lat3_grants", grant_log.size(), 32'd2);
    if (grant_log.size() >= 2) begin
      check("lat3_first", grant_log[0], 32'h20);
      check("lat3_second", grant_log[1], 32'h24);
    end
    tick(1'b0, 1'b1, 32'h0000_0103);
    check("redir_req_low", 32'(imem_req), 32'd0);
    wait_req(32'h100, "redir_first_addr");
    wait_valid(32'h100, "redir_first_pc");

    // Redirect while stalled with a full FIFO
    lat = 1;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'h0);
    check("full_valid", 32'(valid_IF), 32'd1);
    check("full_req", 32'(imem_req), 32'd0);
    tick(1'b1, 1'b1, 32'h0000_2000);
    tick(1'b0, 1'b0, 32'h0);
    check("flush_valid", 32'(valid_IF), 32'd0);
    check("flush_instr", Instr_IF, NOP_INSTR);
    check("flush_req", 32'(imem_req), 32'd1);
    check("flush_addr", imem_addr, 32'h2000);
    wait_valid(32'h2000, "flush_first_pc");

    // Address wrap at the top of the address space
    grant_log.delete();
    tick(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 20 && grant_log.size() < 3; i++) tick(1'b0, 1'b0, 32'h0);
    check("wrap_grants", (grant_log.size() >= 3) ? 32'd3 : grant_log.size(), 32'd3);
    if (grant_log.size() >= 3) begin
      check("wrap_a0", grant_log[0], 32'hFFFF_FFF8);
      check("wrap_a1", grant_log[1], 32'hFFFF_FFFC);
      check("wrap_a2", grant_log[2], 32'h0000_0000);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0);

    // Random grants, latencies, stalls and redirects
    rand_gnt     = 1'b1;
    rand_lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3, $urandom());
    end
    rand_gnt     = 1'b0;
    rand_lat_max = 0;
    lat          = 1;
    gnt_en       = 1'b1;

    // One-cycle reset mid-stream with nothing pending at the memory
    tick(1'b0, 1'b1, 32'h0000_4440);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20 && mem_q.size() > 0; i++) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("midrst_pending", mem_q.size(), 32'd0);
    rst_v = 1'b0;
    tick(1'b1, 1'b0, 32'h0);
    check("midrst_req", 32'(imem_req), 32'd0);
    rst_v = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    check("midrst_valid", 32'(valid_IF), 32'd0);
    check("midrst_pc", PC_IF, RESET_PC);
    check("midrst_instr", Instr_IF, NOP_INSTR);
    check("midrst_req_on", 32'(imem_req), 32'd1);
    check("midrst_addr", imem_addr, RESET_PC);
    wait_valid(RESET_PC, "midrst_first_pc");

    // Stop granting and make sure every expected fetch came out
    gnt_en = 1'b0;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || mem_q.size() > 0); i++) begin
      tick(1'b0, 1'b0, 32'h0);
    end
    tick(1'b0, 1'b0, 32'h0);
    check("drain_left", exp_q.size(), 32'd0);
    check("drain_valid", 32'(valid_IF), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
